// File: rtl/mem_stage.sv
// Memory-access stage: accepts execute results, waits for the load data response, then aligns and extends it for write-back.
// Latency: non-loads take 1 cycle; loads complete in the data_ok cycle, or later if write-back stalls (response parked in HOLD).
// Backpressure: ms_allowin drops while a load awaits data or write-back stalls. Macro MS_LD_FWD_EN makes load data forwardable to decode.
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 74,
    parameter int MS_TO_WS_BUS_WD = 70
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_allowin,
    input  logic                       ws_allowin,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    output logic [31:0]                ms_to_ds_result,
    output logic [4:0]                 MS_dest,
    output logic                       ms_ld_pending
);

    typedef struct packed {
        logic [2:0]  ld_op;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_bus_t;

    typedef struct packed {
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ws_bus_t;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic        ms_valid;
    logic        ms_ready_go;
    logic        load_accept;
    es_bus_t     es_in;
    es_bus_t     ms_bus;
    ws_bus_t     ws_bus;
    logic [31:0] rdata_buf;
    logic [31:0] rd;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;
    logic [31:0] final_result;

    assign es_in = es_to_ms_bus;

    assign ms_ready_go    = !ms_bus.res_from_mem
                          || (state == WAIT && data_sram_data_ok)
                          || (state == HOLD);
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;
    assign load_accept    = es_to_ms_valid && ms_allowin && es_in.res_from_mem;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid <= 1'b0;
            ms_bus   <= '0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
            if (es_to_ms_valid) begin
                ms_bus <= es_in;
            end
        end
    end

    // A fresh load can be accepted on the same edge the previous one retires,
    // so both leaving states fall back to WAIT rather than IDLE in that case.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load_accept) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (data_sram_data_ok) begin
                    if (ws_allowin) begin
                        state_nxt = load_accept ? WAIT : IDLE;
                    end else begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (ws_allowin) begin
                    state_nxt = load_accept ? WAIT : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rdata_buf <= '0;
        end else begin
            state <= state_nxt;
            if (state == WAIT && data_sram_data_ok && !ws_allowin) begin
                rdata_buf <= data_sram_rdata;
            end
        end
    end

    // The SRAM bus is only meaningful in the data_ok cycle; HOLD replays the parked copy.
    always_comb begin
        rd = (state == HOLD) ? rdata_buf : data_sram_rdata;
        case (ms_bus.alu_result[1:0])
            2'd0:    ld_byte = rd[7:0];
            2'd1:    ld_byte = rd[15:8];
            2'd2:    ld_byte = rd[23:16];
            default: ld_byte = rd[31:24];
        endcase
        ld_half = ms_bus.alu_result[1] ? rd[31:16] : rd[15:0];
        case (ms_bus.ld_op)
            3'd1:    load_data = {{24{ld_byte[7]}}, ld_byte};
            3'd2:    load_data = {24'b0, ld_byte};
            3'd3:    load_data = {{16{ld_half[15]}}, ld_half};
            3'd4:    load_data = {16'b0, ld_half};
            default: load_data = rd;
        endcase
    end

    assign final_result = ms_bus.res_from_mem ? load_data : ms_bus.alu_result;

    always_comb begin
        ws_bus.gr_we        = ms_bus.gr_we;
        ws_bus.dest         = ms_bus.dest;
        ws_bus.final_result = final_result;
        ws_bus.pc           = ms_bus.pc;
    end

    assign ms_to_ws_bus = ws_bus;
    assign MS_dest      = ms_bus.dest & {5{ms_valid && ms_bus.gr_we}};

`ifdef MS_LD_FWD_EN
    assign ms_to_ds_result = final_result;
    assign ms_ld_pending   = ms_valid && ms_bus.res_from_mem && !ms_ready_go;
`else
    // Without forwarding, decode sees only the ALU value and must stall on any resident load.
    assign ms_to_ds_result = ms_bus.alu_result;
    assign ms_ld_pending   = ms_valid && ms_bus.res_from_mem;
`endif

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        es_to_ms_valid;
    logic [73:0] es_to_ms_bus;
    logic        ms_allowin;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [31:0] ms_to_ds_result;
    logic [4:0]  MS_dest;
    logic        ms_ld_pending;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_allowin        (ms_allowin),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ms_to_ds_result   (ms_to_ds_result),
        .MS_dest           (MS_dest),
        .ms_ld_pending     (ms_ld_pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  ld_op;
        logic        rfm;
        logic        we;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    function automatic logic [73:0] mk_bus(input logic [2:0] op, input logic rfm, input logic we,
                                           input logic [4:0] dest, input logic [31:0] alu,
                                           input logic [31:0] pc);
        return {op, rfm, we, dest, alu, pc};
    endfunction

    initial begin
        logic [31:0] pc;
        logic [31:0] exp_ds;
        logic        exp_pend;
        logic [4:0]  exp_dest;

        vt[0]  = {3'd0, 1'b1, 1'b1, 5'd5,  32'h0000_1000, 32'h8081_8283, 32'h8081_8283};
        vt[1]  = {3'd1, 1'b1, 1'b1, 5'd6,  32'h0000_1003, 32'h8000_0000, 32'hFFFF_FF80};
        vt[2]  = {3'd2, 1'b1, 1'b1, 5'd7,  32'h0000_1003, 32'h8000_0000, 32'h0000_0080};
        vt[3]  = {3'd1, 1'b1, 1'b1, 5'd8,  32'h0000_1000, 32'h0000_007F, 32'h0000_007F};
        vt[4]  = {3'd3, 1'b1, 1'b1, 5'd9,  32'h0000_1002, 32'h8000_1234, 32'hFFFF_8000};
        vt[5]  = {3'd4, 1'b1, 1'b1, 5'd10, 32'h0000_1000, 32'h8000_1234, 32'h0000_1234};
        vt[6]  = {3'd1, 1'b1, 1'b1, 5'd11, 32'h0000_1001, 32'h0000_FF00, 32'hFFFF_FFFF};
        vt[7]  = {3'd4, 1'b1, 1'b1, 5'd12, 32'h0000_1002, 32'hFFFF_0000, 32'h0000_FFFF};
        vt[8]  = {3'd6, 1'b1, 1'b1, 5'd13, 32'h0000_2001, 32'hCAFE_F00D, 32'hCAFE_F00D};
        vt[9]  = {3'd2, 1'b1, 1'b0, 5'd14, 32'h0000_1001, 32'h0000_A500, 32'h0000_00A5};
        vt[10] = {3'd1, 1'b0, 1'b1, 5'd15, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678};
        vt[11] = {3'd0, 1'b0, 1'b0, 5'd16, 32'h0BAD_F00D, 32'h0000_0000, 32'h0BAD_F00D};

        reset = 1'b1;
        es_to_ms_valid = 1'b0;
        es_to_ms_bus = '0;
        ws_allowin = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata = '0;

        #2;
        chk("rst_to_ws_valid", 70'(ms_to_ws_valid), 70'(0));
        chk("rst_allowin", 70'(ms_allowin), 70'(1));
        chk("rst_ms_dest", 70'(MS_dest), 70'(0));
        chk("rst_ld_pending", 70'(ms_ld_pending), 70'(0));
        chk("rst_ws_bus", ms_to_ws_bus, 70'(0));
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        // Table: each record is issued alone and retired before the next.
        for (int i = 0; i < 12; i++) begin
            pc = 32'h1c00_0000 + 32'(i * 4);
            exp_dest = vt[i].we ? vt[i].dest : 5'd0;
            cyc();
            es_to_ms_valid = 1'b1;
            es_to_ms_bus = mk_bus(vt[i].ld_op, vt[i].rfm, vt[i].we, vt[i].dest, vt[i].alu, pc);
            data_sram_data_ok = 1'b0;
            data_sram_rdata = '0;
            ws_allowin = 1'b1;
            smp();
            chk($sformatf("v%0d_empty_allowin", i), 70'(ms_allowin), 70'(1));
            chk($sformatf("v%0d_empty_valid", i), 70'(ms_to_ws_valid), 70'(0));
            cyc();
            es_to_ms_valid = 1'b0;
            smp();
            if (vt[i].rfm) begin
                chk($sformatf("v%0d_wait_valid", i), 70'(ms_to_ws_valid), 70'(0));
                chk($sformatf("v%0d_wait_allowin", i), 70'(ms_allowin), 70'(0));
                chk($sformatf("v%0d_wait_pending", i), 70'(ms_ld_pending), 70'(1));
                chk($sformatf("v%0d_wait_dest", i), 70'(MS_dest), 70'(exp_dest));
                cyc();
                data_sram_data_ok = 1'b1;
                data_sram_rdata = vt[i].rdata;
                smp();
`ifdef MS_LD_FWD_EN
                exp_ds = vt[i].exp;
                exp_pend = 1'b0;
`else
                exp_ds = vt[i].alu;
                exp_pend = 1'b1;
`endif
                chk($sformatf("v%0d_ok_pending", i), 70'(ms_ld_pending), 70'(exp_pend));
                chk($sformatf("v%0d_ok_allowin", i), 70'(ms_allowin), 70'(1));
            end else begin
                exp_ds = vt[i].alu;
                chk($sformatf("v%0d_pending", i), 70'(ms_ld_pending), 70'(0));
            end
            chk($sformatf("v%0d_valid", i), 70'(ms_to_ws_valid), 70'(1));
            chk($sformatf("v%0d_bus", i), ms_to_ws_bus, {vt[i].we, vt[i].dest, vt[i].exp, pc});
            chk($sformatf("v%0d_ds_result", i), 70'(ms_to_ds_result), 70'(exp_ds));
            chk($sformatf("v%0d_dest", i), 70'(MS_dest), 70'(exp_dest));
        end

        // Five back-to-back non-loads: output for instruction k-1 appears while k is offered.
        for (int k = 0; k < 6; k++) begin
            cyc();
            data_sram_data_ok = 1'b0;
            if (k < 5) begin
                es_to_ms_valid = 1'b1;
                es_to_ms_bus = mk_bus(3'd0, 1'b0, (k % 2) == 0, 5'(k + 1),
                                      32'hA000_0000 + 32'(k), 32'h1c00_1000 + 32'(k * 4));
            end else begin
                es_to_ms_valid = 1'b0;
            end
            smp();
            if (k > 0) begin
                chk($sformatf("b2b%0d_valid", k - 1), 70'(ms_to_ws_valid), 70'(1));
                chk($sformatf("b2b%0d_allowin", k - 1), 70'(ms_allowin), 70'(1));
                chk($sformatf("b2b%0d_bus", k - 1), ms_to_ws_bus,
                    {((k - 1) % 2) == 0, 5'(k), 32'hA000_0000 + 32'(k - 1), 32'h1c00_1000 + 32'((k - 1) * 4)});
                chk($sformatf("b2b%0d_dest", k - 1), 70'(MS_dest), 70'(((k - 1) % 2) == 0 ? 5'(k) : 5'd0));
            end
        end

        // Write-back stall in the data_ok cycle parks the response in HOLD.
        cyc();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_bus(3'd0, 1'b1, 1'b1, 5'd3, 32'h0000_3000, 32'h1c00_2000);
        cyc();
        es_to_ms_valid = 1'b0;
        smp();
        chk("hold_pre_valid", 70'(ms_to_ws_valid), 70'(0));
        cyc();
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'hDEAD_BEEF;
        ws_allowin = 1'b0;
        smp();
        chk("hold_ok_valid", 70'(ms_to_ws_valid), 70'(1));
        chk("hold_ok_allowin", 70'(ms_allowin), 70'(0));
        chk("hold_ok_bus", ms_to_ws_bus, {1'b1, 5'd3, 32'hDEAD_BEEF, 32'h1c00_2000});
        cyc();
        data_sram_data_ok = 1'b0;
        data_sram_rdata = '0;
        smp();
`ifdef MS_LD_FWD_EN
        exp_ds = 32'hDEAD_BEEF;
        exp_pend = 1'b0;
`else
        exp_ds = 32'h0000_3000;
        exp_pend = 1'b1;
`endif
        chk("hold_valid", 70'(ms_to_ws_valid), 70'(1));
        chk("hold_allowin", 70'(ms_allowin), 70'(0));
        chk("hold_bus", ms_to_ws_bus, {1'b1, 5'd3, 32'hDEAD_BEEF, 32'h1c00_2000});
        chk("hold_pending", 70'(ms_ld_pending), 70'(exp_pend));
        chk("hold_ds_result", 70'(ms_to_ds_result), 70'(exp_ds));
        cyc();
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h1111_1111;
        smp();
        chk("hold_spurious_ok_bus", ms_to_ws_bus, {1'b1, 5'd3, 32'hDEAD_BEEF, 32'h1c00_2000});
        cyc();
        data_sram_data_ok = 1'b0;
        data_sram_rdata = '0;
        ws_allowin = 1'b1;
        smp();
        chk("hold_rel_valid", 70'(ms_to_ws_valid), 70'(1));
        chk("hold_rel_allowin", 70'(ms_allowin), 70'(1));
        chk("hold_rel_bus", ms_to_ws_bus, {1'b1, 5'd3, 32'hDEAD_BEEF, 32'h1c00_2000});
        cyc();
        smp();
        chk("hold_after_valid", 70'(ms_to_ws_valid), 70'(0));
        chk("hold_after_dest", 70'(MS_dest), 70'(0));

        // Asynchronous reset while a load waits in WAIT, then a fresh load.
        cyc();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_bus(3'd0, 1'b1, 1'b1, 5'd4, 32'h0000_4000, 32'h1c00_3000);
        cyc();
        es_to_ms_valid = 1'b0;
        smp();
        chk("arst_pre_dest", 70'(MS_dest), 70'(4));
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", 70'(ms_to_ws_valid), 70'(0));
        chk("arst_dest", 70'(MS_dest), 70'(0));
        chk("arst_allowin", 70'(ms_allowin), 70'(1));
        chk("arst_pending", 70'(ms_ld_pending), 70'(0));
        #1 reset = 1'b0;
        cyc();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_bus(3'd4, 1'b1, 1'b1, 5'd6, 32'h0000_5002, 32'h1c00_3004);
        cyc();
        es_to_ms_valid = 1'b0;
        smp();
        chk("post_wait_valid", 70'(ms_to_ws_valid), 70'(0));
        chk("post_wait_pending", 70'(ms_ld_pending), 70'(1));
        chk("post_wait_dest", 70'(MS_dest), 70'(6));
        cyc();
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'hABCD_0000;
        smp();
        chk("post_ok_valid", 70'(ms_to_ws_valid), 70'(1));
        chk("post_ok_bus", ms_to_ws_bus, {1'b1, 5'd6, 32'h0000_ABCD, 32'h1c00_3004});
        cyc();
        data_sram_data_ok = 1'b0;
        data_sram_rdata = '0;
        smp();
        chk("post_after_valid", 70'(ms_to_ws_valid), 70'(0));
        chk("post_after_allowin", 70'(ms_allowin), 70'(1));

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access pipeline stage. It accepts instructions from the execute stage through a valid/allowin handshake. For loads, it waits for the data SRAM response, then aligns and extends the loaded data. It drives the 70-bit bus into the write-back stage, and exports a bypass result plus a destination register number to decode.

Parameters:
ES_TO_MS_BUS_WD, 74, width of the incoming bus from execute
MS_TO_WS_BUS_WD, 70, width of the outgoing bus to write-back

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
es_to_ms_valid  input  1  execute stage offers an instruction
es_to_ms_bus  input  74  {ld_op[73:71], res_from_mem[70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}
ms_allowin  output  1  this stage can accept an instruction this cycle
ws_allowin  input  1  write-back stage can accept an instruction
ms_to_ws_valid  output  1  valid instruction offered to write-back
ms_to_ws_bus  output  70  {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}
data_sram_data_ok  input  1  load data returned this cycle (one-cycle pulse)
data_sram_rdata  input  32  returned word, valid when data_ok=1
ms_to_ds_result  output  32  bypass value to decode
MS_dest  output  5  destination register for bypass; 0 when the stage is empty
ms_ld_pending  output  1  valid load whose data is not yet forwardable

Behaviour:
- Reset (async): ms_valid=0, state=IDLE, bus register and rdata_buf cleared.
  - Consequences: ms_to_ws_valid=0, ms_allowin=1, MS_dest=0, ms_ld_pending=0.
- Bus register:
  - Loaded with es_to_ms_bus when es_to_ms_valid && ms_allowin.
  - On the same edge, ms_valid <= es_to_ms_valid whenever ms_allowin.
- Handshake:
  - ms_ready_go = !res_from_mem || (state==WAIT && data_ok) || state==HOLD.
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - ms_to_ws_valid = ms_valid && ms_ready_go.
  - Latency: non-load instructions 1 cycle; loads complete in the data_ok cycle at the earliest.
- State machine (loads only):
  - IDLE -> WAIT: load accepted.
  - WAIT & data_ok & ws_allowin: result passes straight through. Next state is WAIT if a new load is accepted on the same edge, otherwise IDLE.
  - WAIT & data_ok & !ws_allowin -> HOLD: rdata_buf <= data_sram_rdata.
  - HOLD & ws_allowin: leaves HOLD. Next state is WAIT if a new load is accepted, otherwise IDLE.
  - HOLD: data_ok must not arrive; it is ignored if it does.
  - Non-loads never leave IDLE.
- Ordering: at most one outstanding request. Execute issues a request only when ms_allowin permits. Responses arrive in order, never before the load enters this stage.
- Load data: rd = (state==HOLD) ? rdata_buf : data_sram_rdata. a = alu_result[1:0].
  - ld_op 0 lw: rd.
  - ld_op 1 lb: sign-extend byte a.
  - ld_op 2 lbu: zero-extend byte a.
  - ld_op 3 lh: sign-extend half a[1] (a[0] assumed 0).
  - ld_op 4 lhu: zero-extend half a[1].
  - ld_op 5-7: treated as lw.
- final_result = res_from_mem ? load_data : alu_result.
- MS_dest = dest & {5{ms_valid && gr_we}}.
- Reset mid-operation: state returns to IDLE immediately. The system must not deliver a stale response after reset.

Optional Feature:
Macro MS_LD_FWD_EN.
- Defined:
  - ms_to_ds_result = final_result.
  - ms_ld_pending = ms_valid && res_from_mem && !ms_ready_go.
  - Decode may forward load data in the data_ok cycle or from HOLD.
- Undefined:
  - ms_to_ds_result = alu_result.
  - ms_ld_pending = ms_valid && res_from_mem for the whole residency, so decode must stall on any load here.

Test Plan:
- lw: alu_result=0x1000, data_ok two cycles after accept, rdata=0x80818283, ws_allowin=1 -> ms_to_ws_valid high only in the data_ok cycle, final_result=0x80818283, ms_allowin=0 for the prior cycles.
- lb / lbu, a=3, rdata=0x80000000 -> 0xFFFFFF80 / 0x00000080. lb, a=0, rdata=0x0000007F -> 0x0000007F.
- lh, a=2, rdata=0x80001234 -> 0xFFFF8000. lhu, a=0, same rdata -> 0x00001234.
- Load with ws_allowin=0 during data_ok=1 (rdata=0xDEADBEEF), rdata bus then changed to 0 -> HOLD, ms_to_ws_valid=1, result stays 0xDEADBEEF until ws_allowin=1. Released the next edge.
- Five back-to-back non-loads, ws_allowin=1 -> one output per cycle, each with final_result=alu_result. MS_dest=dest when gr_we=1, 0 when gr_we=0.
- reset pulsed asynchronously while in WAIT -> ms_valid, ms_to_ws_valid, MS_dest go to 0 without waiting for a clock edge. The next load accepted behaves as a fresh IDLE->WAIT. Check ms_ld_pending under both macro settings.
